// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Instruction fetch sequencer. Owns the program counter, reads 16-bit
// instruction words from instruction memory over a req/ack handshake and
// presents each fetched word on INST for exactly one clock. Every other cycle
// INST carries a NOP bubble so the decoder can decode unconditionally.
//
// Ports:
//   clk        - single clock, all state updates on posedge
//   res        - synchronous active-low reset
//   run        - fetch enable
//   stall      - downstream hazard hold, suppresses issue
//   jmp_en     - one-cycle jump request
//   jmp_addr   - jump target
//   mem_req    - memory read request
//   mem_addr   - read address (always the PC)
//   mem_ack    - read data valid this cycle
//   mem_rdata  - instruction word from memory
//   INST       - registered instruction to the decoder
//   pc         - current PC (debug)
//   fault      - sticky fetch timeout flag
//
// The NOP word carries OP_NOP in the opcode field INST[15:12] and zeros in
// every other bit.
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
  parameter int              TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            res,
  input  logic            run,
  input  logic            stall,
  input  logic            jmp_en,
  input  logic [PC_W-1:0] jmp_addr,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [15:0]     mem_rdata,
  output logic [15:0]     INST,
  output logic [PC_W-1:0] pc,
  output logic            fault
);

  localparam logic [3:0]  OP_NOP   = 4'hF;
  localparam logic [15:0] NOP_WORD = {OP_NOP, 12'h000};

  // Wait counter only needs to reach TIMEOUT; with TIMEOUT=0 it simply wraps.
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_ISSUE = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [PC_W-1:0]   pc_r, pc_nxt_s;
  logic [15:0]       ibuf_r, ibuf_nxt_s;
  logic [15:0]       inst_r, inst_nxt_s;
  logic [WAIT_W-1:0] wait_r, wait_nxt_s;
  logic [WAIT_W-1:0] wait_inc_s;

  assign wait_inc_s = wait_r + WAIT_W'(1);

  // Outputs decode purely from registers: no input-to-output path.
  assign mem_req  = (state_r == S_REQ);
  assign mem_addr = pc_r;
  assign pc       = pc_r;
  assign fault    = (state_r == S_FAULT);
  assign INST     = inst_r;

  // Next-state and next-register logic; a jump outranks every other event.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    ibuf_nxt_s  = ibuf_r;
    wait_nxt_s  = wait_r;
    inst_nxt_s  = NOP_WORD;

    if (jmp_en && (state_r != S_FAULT)) begin
      // Same-cycle ack and any buffered word are dropped.
      pc_nxt_s    = jmp_addr;
      ibuf_nxt_s  = 16'h0000;
      wait_nxt_s  = {WAIT_W{1'b0}};
      state_nxt_s = run ? S_REQ : S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (run) begin
            state_nxt_s = S_REQ;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_REQ: begin
          // run is deliberately ignored here: a started request completes.
          if (mem_ack) begin
            ibuf_nxt_s  = mem_rdata;
            wait_nxt_s  = {WAIT_W{1'b0}};
            state_nxt_s = S_ISSUE;
          end else begin
            wait_nxt_s = wait_inc_s;
            if ((TIMEOUT != 0) && (wait_inc_s == TIMEOUT_C)) begin
              state_nxt_s = S_FAULT;
            end else begin
              state_nxt_s = S_REQ;
            end
          end
        end
        S_ISSUE: begin
          if (stall) begin
            state_nxt_s = S_ISSUE;
          end else begin
            inst_nxt_s  = ibuf_r;
            pc_nxt_s    = pc_r + PC_W'(1);
            state_nxt_s = run ? S_REQ : S_IDLE;
          end
        end
        S_FAULT: begin
          state_nxt_s = S_FAULT;
        end
        default: begin
          state_nxt_s = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!res) begin
      state_r <= S_IDLE;
      pc_r    <= RESET_PC;
      ibuf_r  <= 16'h0000;
      inst_r  <= NOP_WORD;
      wait_r  <= {WAIT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      ibuf_r  <= ibuf_nxt_s;
      inst_r  <= inst_nxt_s;
      wait_r  <= wait_nxt_s;
    end
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch sequencer for CPU1. It owns the program counter and reads 16-bit instruction words from instruction memory over a req/ack handshake. It drives the `INST` bus of the instruction decoder, presenting each fetched word for exactly one clock. When no instruction is being issued, it inserts NOP bubbles so the decoder can decode unconditionally every cycle.

## Interface
Parameters:
- `PC_W`, default 8: program counter / memory address width.
- `RESET_PC`, default 0: PC value loaded on reset.
- `TIMEOUT`, default 16: maximum consecutive unacknowledged request cycles before fault. 0 disables the timeout.

Ports:
- `clk` input, 1 bit: single clock. All logic updates on the posedge.
- `res` input, 1 bit: reset, synchronous and active-low.
- `run` input, 1 bit: fetch enable.
- `stall` input, 1 bit: downstream hazard hold. Suppresses issue.
- `jmp_en` input, 1 bit: one-cycle jump request.
- `jmp_addr` input, `PC_W` bits: jump target.
- `mem_req` output, 1 bit: memory read request.
- `mem_addr` output, `PC_W` bits: read address, equal to PC.
- `mem_ack` input, 1 bit: read data valid this cycle.
- `mem_rdata` input, 16 bits: instruction word.
- `INST` output, 16 bits: instruction to the decoder. Registered.
- `pc` output, `PC_W` bits: current PC, for debug.
- `fault` output, 1 bit: sticky fetch timeout flag.

## Operation
- The state register has four states: S_IDLE, S_REQ, S_ISSUE, S_FAULT.
- NOP word: `OP_NOP` in `INST[INST_OP]`, all other bits 0.
- S_IDLE
  - `mem_req`=0.
  - `run`=1 → S_REQ.
- S_REQ
  - `mem_req`=1, `mem_addr`=PC.
  - `mem_ack`=1 → capture `mem_rdata` into the internal buffer `ibuf`, clear the wait counter, go to S_ISSUE.
  - `mem_ack`=0 → increment the wait counter. If `TIMEOUT`≠0 and the counter reaches `TIMEOUT`, go to S_FAULT.
  - A started request is never abandoned because of `run`=0.
- S_ISSUE
  - `stall`=1 → stay in S_ISSUE. `INST` gets NOP.
  - `stall`=0 → `INST` gets `ibuf`, PC increments by 1 modulo 2^`PC_W` (wraps from all-ones to 0). Next state is S_REQ if `run`=1, else S_IDLE.
- S_FAULT
  - Absorbing; only reset exits.
  - `mem_req`=0, `INST`=NOP, `fault`=1. `jmp_en` is ignored.
- `INST` carries NOP in every cycle except the single cycle following an S_ISSUE cycle with `stall`=0.
- Jump (`jmp_en`=1 in any state except S_FAULT) has priority over every other event in that cycle:
  - PC gets `jmp_addr`.
  - `ibuf` contents and any ack arriving in the same cycle are discarded.
  - `INST` gets NOP.
  - Wait counter clears.
  - Next state is S_REQ if `run`=1, else S_IDLE.
- `mem_req`, `mem_addr`, `pc` and `fault` decode directly from registers. There is no combinational input-to-output path.

## Timing
- Reset (`res`=0 at a posedge):
  - state=S_IDLE, PC=`RESET_PC`, `ibuf`=0, wait counter=0.
  - `INST`=NOP, `mem_req`=0, `mem_addr`=`RESET_PC`, `pc`=`RESET_PC`, `fault`=0.
- Reset overrides everything, including a mid-request or S_FAULT state. The memory side must tolerate the request being dropped.
- Latency:
  - `run` rises in cycle 0 (S_IDLE) → `mem_req`=1 in cycle 1.
  - Ack in cycle 1 → S_ISSUE in cycle 2 → `INST` valid in cycle 3, and `mem_req`=1 again for PC+1 in cycle 3.
- Throughput: one instruction per 2 cycles at zero memory wait. Each wait cycle adds 1 cycle.
- Each stall cycle in S_ISSUE delays issue by 1 cycle. The held word is not lost.
- Fault: with `TIMEOUT`=T and no ack, `mem_req` is high for exactly T cycles, then `fault`=1 in the next cycle.
- Jump in cycle n → `mem_req`=1 with `mem_addr`=`jmp_addr` in cycle n+1 (when `run`=1).

## Test plan
- Reset then `run`=1, memory acks every request with data = {8'h00, addr}, no stall → `INST` sequence NOP-bubbled 0x0000, 0x0001, 0x0002 on alternate cycles; `mem_addr` 0, 1, 2.
- `PC_W`=8, `jmp_addr`=8'hFE, run through wrap → fetch addresses FE, FF, 00, 01.
- `stall`=1 for 3 cycles in S_ISSUE with `ibuf`=16'h1234 → `INST`=NOP for those 3 cycles, then 16'h1234 for one cycle, PC incremented once only.
- `jmp_en`=1 with `jmp_addr`=8'h40 in the same cycle as `mem_ack` for addr 8'h05 → ack data never appears on `INST`; next `mem_addr`=8'h40.
- `TIMEOUT`=4, `mem_ack` held 0 → `mem_req` high 4 cycles, then `fault`=1 and `INST`=NOP permanently. `jmp_en` ignored. `res`=0 clears `fault` and restores PC=`RESET_PC`.
- `run` dropped while in S_REQ with 2 wait cycles → ack still accepted, instruction issued once, then S_IDLE with `mem_req`=0; `res`=0 asserted mid-request → all outputs at reset values next cycle.
